// File: rtl/clkdiv_ctrl_pkg.sv
// clkdiv_ctrl_pkg: shared state encoding and reset ratio for the clock divider controller
package clkdiv_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;
    localparam int CLKDIV_DEFAULT_MAX = 5;
endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: half-period counter that wraps to zero at max
// Ports: clk, rst (async, active-high), clear (sync zero), enable (count),
//        max (last count value), count (current value), wrap (count==max while enabled)
module clkdiv_counter #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] max,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   wrap
);
    assign wrap = enable && (count == max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= wrap ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: glitch-free run-time programmable clock divider controller
// Ports: clk, rst (async, active-high), en (run level), cfg_max/cfg_valid/cfg_ready
//        (new half-period-minus-1 handshake), out (divided clock), tick (out changed),
//        busy (not idle), cur_max (ratio in use)
module clkdiv_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 4,
    parameter int DEFAULT_MAX = CLKDIV_DEFAULT_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] cfg_max,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   out,
    output logic                   tick,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] cur_max
);
    state_t                 state, state_nxt;
    logic                   pend;
    logic [COUNT_WIDTH-1:0] pend_max;
    logic [COUNT_WIDTH-1:0] count;
    logic                   wrap, clear, out_nxt, apply, accept;

    assign busy      = (state != IDLE);
    assign cfg_ready = ~pend;
    assign accept    = cfg_valid && !pend;
    // A pending ratio lands immediately when idle, otherwise only on a falling edge of out
    assign apply     = pend && ((state == IDLE) || (wrap && out));
    assign clear     = (state_nxt == IDLE) || apply;

    clkdiv_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (busy),
        .max    (cur_max),
        .count  (count),
        .wrap   (wrap)
    );

    always_comb begin
        state_nxt = state;
        out_nxt   = out ^ wrap;
        case (state)
            IDLE: begin
                state_nxt = en ? RUN : IDLE;
                out_nxt   = 1'b0;
            end
            RUN: begin
                // Stopping while low leaves out low; while high, let the high phase finish
                if (!en) begin
                    state_nxt = (out && !wrap) ? STOPPING : IDLE;
                    out_nxt   = out && !wrap;
                end
            end
            STOPPING: state_nxt = en ? RUN : (wrap ? IDLE : STOPPING);
            default: begin
                state_nxt = IDLE;
                out_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= 1'b0;
            tick     <= 1'b0;
            pend     <= 1'b0;
            pend_max <= '0;
            cur_max  <= COUNT_WIDTH'(DEFAULT_MAX);
        end else begin
            out  <= out_nxt;
            tick <= out_nxt ^ out;
            pend <= apply ? 1'b0 : (accept ? 1'b1 : pend);
            if (accept)
                pend_max <= cfg_max;
            if (apply)
                cur_max <= pend_max;
        end
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: scoreboard bench; stimulus queues expected toggles, monitor checks each tick
`timescale 1ns/1ps
module tb_clkdiv_ctrl;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, cfg_valid = 1'b0;
    logic [3:0] cfg_max = 4'd0;
    logic       cfg_ready, out, tick, busy;
    logic [3:0] cur_max;

    typedef struct {
        logic       o;
        logic [3:0] m;
        int         g;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    clkdiv_ctrl #(.COUNT_WIDTH(4), .DEFAULT_MAX(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_max   (cfg_max),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .out       (out),
        .tick      (tick),
        .busy      (busy),
        .cur_max   (cur_max)
    );

    always #41.667 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_tick(input logic o, input logic [3:0] m, input int g);
        exp_t e;
        e.o = o;
        e.m = m;
        e.g = g;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(posedge clk);
            #1;
            if (tick) seen++;
        end
        if (seen < n) chk("tick_timeout", seen, n);
    endtask

    // Monitor: gap is measured from RUN entry (busy rising) or the previous tick
    initial begin
        int   cyc;
        int   last;
        logic pb;
        exp_t e;
        cyc = 0;
        last = 0;
        pb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && !pb) last = cyc;
            pb = busy;
            if (tick) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_tick: tick=1 at cycle %0d, required no tick", cyc);
                end else begin
                    e = q.pop_front();
                    chk("tick_out", int'(out), int'(e.o));
                    chk("tick_cur_max", int'(cur_max), int'(e.m));
                    chk("tick_gap", cyc - last, e.g);
                end
                last = cyc;
            end
        end
    end

    initial begin
        #10 rst = 1'b1;
        #20 rst = 1'b0;
        chk("rst_out", int'(out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_cur_max", int'(cur_max), 5);
        chk("rst_busy", int'(busy), 0);
        #70 en = 1'b1;
        expect_tick(1, 5, 6);
        expect_tick(0, 5, 6);
        expect_tick(1, 5, 6);
        wait_ticks(3);
        chk("run_busy", int'(busy), 1);
        expect_tick(0, 2, 6);
        expect_tick(1, 2, 3);
        expect_tick(0, 2, 3);
        cfg_max = 4'd2;
        cfg_valid = 1'b1;
        cycles(1);
        cfg_valid = 1'b0;
        chk("cfg2_ready_low", int'(cfg_ready), 0);
        chk("cfg2_not_yet", int'(cur_max), 5);
        wait_ticks(3);
        chk("cfg2_ready_back", int'(cfg_ready), 1);
        expect_tick(1, 2, 3);
        wait_ticks(1);
        en = 1'b0;
        expect_tick(0, 2, 3);
        cycles(1);
        chk("stopping_busy", int'(busy), 1);
        wait_ticks(1);
        chk("stop_hi_busy", int'(busy), 0);
        chk("stop_hi_out", int'(out), 0);
        cycles(5);
        chk("stop_hi_out_hold", int'(out), 0);
        en = 1'b1;
        expect_tick(1, 2, 3);
        expect_tick(0, 2, 3);
        wait_ticks(2);
        en = 1'b0;
        cycles(1);
        chk("stop_lo_busy", int'(busy), 0);
        chk("stop_lo_out", int'(out), 0);
        cycles(4);
        cfg_max = 4'd0;
        cfg_valid = 1'b1;
        cycles(1);
        cfg_valid = 1'b0;
        chk("cfg0_ready_low", int'(cfg_ready), 0);
        cycles(1);
        chk("cfg0_applied_idle", int'(cur_max), 0);
        chk("cfg0_ready_back", int'(cfg_ready), 1);
        expect_tick(1, 0, 1);
        expect_tick(0, 0, 1);
        expect_tick(1, 0, 1);
        expect_tick(0, 0, 1);
        en = 1'b1;
        wait_ticks(4);
        en = 1'b0;
        cycles(2);
        chk("div2_stop_busy", int'(busy), 0);
        cfg_max = 4'd3;
        cfg_valid = 1'b1;
        cycles(1);
        cfg_valid = 1'b0;
        cycles(1);
        chk("cfg3_applied_idle", int'(cur_max), 3);
        expect_tick(1, 3, 4);
        en = 1'b1;
        wait_ticks(1);
        expect_tick(0, 1, 4);
        expect_tick(1, 1, 2);
        expect_tick(0, 1, 2);
        cfg_max = 4'd1;
        cfg_valid = 1'b1;
        cycles(1);
        chk("cfg1_ready_low", int'(cfg_ready), 0);
        cfg_max = 4'd7;
        cycles(1);
        cfg_valid = 1'b0;
        wait_ticks(3);
        chk("cfg1_ready_back", int'(cfg_ready), 1);
        expect_tick(1, 1, 2);
        wait_ticks(1);
        expect_tick(0, 1, 2);
        expect_tick(1, 1, 2);
        expect_tick(0, 4, 2);
        expect_tick(1, 4, 5);
        cycles(1);
        cfg_max = 4'd4;
        cfg_valid = 1'b1;
        cycles(1);
        cfg_valid = 1'b0;
        chk("same_edge_not_applied", int'(cur_max), 1);
        chk("same_edge_pend", int'(cfg_ready), 0);
        chk("same_edge_out", int'(out), 0);
        wait_ticks(3);
        chk("same_edge_ready_back", int'(cfg_ready), 1);
        cfg_max = 4'd6;
        cfg_valid = 1'b1;
        cycles(1);
        cfg_valid = 1'b0;
        chk("pre_rst_pend", int'(cfg_ready), 0);
        chk("pre_rst_out", int'(out), 1);
        cycles(1);
        chk("pre_rst_queue", q.size(), 0);
        #10 rst = 1'b1;
        en = 1'b0;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_cur_max", int'(cur_max), 5);
        chk("arst_cfg_ready", int'(cfg_ready), 1);
        chk("arst_busy", int'(busy), 0);
        #20 rst = 1'b0;
        cycles(3);
        chk("arst_pend_discarded", int'(cur_max), 5);
        chk("arst_idle", int'(busy), 0);
        chk("final_queue", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
